// File: rtl/edge_event_unit.sv
// edge_event_unit: per-channel synchroniser, counting glitch filter, edge
// pulse generator and mode-qualified sticky flag / saturating event counter.
// Channels are fully independent; irq is the OR of all sticky flags.
module edge_event_unit #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       sig_in,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       clear,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS-1:0]       pos_pulse,
    output logic [CHANNELS-1:0]       neg_pulse,
    output logic [CHANNELS-1:0]       event_flag,
    output logic [CHANNELS*CNT_W-1:0] event_count,
    output logic                      irq
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);

    // Filter counter value at which a persisting new level is accepted.
    localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [FW-1:0]    FILT_ONE  = FW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q,  sync_d;
    logic [CHANNELS-1:0][FW-1:0]          filt_q,  filt_d;
    logic [CHANNELS-1:0]                  level_q, level_d;
    logic [CHANNELS-1:0]                  level_dly_q, level_dly_d;
    logic [CHANNELS-1:0]                  flag_q,  flag_d;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q,   cnt_d;

    logic [CHANNELS-1:0] sync_w;
    logic [CHANNELS-1:0] mode_rise;
    logic [CHANNELS-1:0] mode_fall;
    logic [CHANNELS-1:0] qual;

    // Split the packed mode bus into per-channel rise/fall enables and pick
    // the last synchroniser stage of each channel.
    always_comb begin
        mode_rise = '0;
        mode_fall = '0;
        sync_w    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mode_rise[i] = mode[2*i];
            mode_fall[i] = mode[2*i+1];
            sync_w[i]    = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Pulses come straight from the level / delayed-level registers, so they
    // are zero in reset and vanish the moment reset is asserted.
    assign pos_pulse = level_q & ~level_dly_q;
    assign neg_pulse = ~level_q & level_dly_q;
    assign qual      = (pos_pulse & mode_rise) | (neg_pulse & mode_fall);

    assign level       = level_q;
    assign event_flag  = flag_q;
    assign event_count = cnt_q;
    assign irq         = |flag_q;

    // Next-state logic: synchroniser shift, filter, edge delay, flag, counter.
    always_comb begin
        sync_d      = sync_q;
        filt_d      = filt_q;
        level_d     = level_q;
        level_dly_d = level_q;
        flag_d      = flag_q;
        cnt_d       = cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], sig_in[i]};

            if (sync_w[i] == level_q[i]) begin
                filt_d[i] = '0;
            end else if (filt_q[i] == FILT_LAST) begin
                level_d[i] = ~level_q[i];
                filt_d[i]  = '0;
            end else begin
                filt_d[i] = filt_q[i] + FILT_ONE;
            end

            // A qualified edge beats a simultaneous clear.
            flag_d[i] = qual[i] | (flag_q[i] & ~clear[i]);

            if (clear[i]) begin
                cnt_d[i] = qual[i] ? CNT_ONE : '0;
            end else if (qual[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            filt_q      <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            flag_q      <= '0;
            cnt_q       <= '0;
        end else begin
            sync_q      <= sync_d;
            filt_q      <= filt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            flag_q      <= flag_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_edge_event_unit.sv
// Testbench for edge_event_unit: directed scenarios plus a randomized run
// compared cycle by cycle against a history-based reference model.
module tb_edge_event_unit;

    localparam int CH   = 4;
    localparam int SS   = 2;
    localparam int FC   = 4;
    localparam int CW   = 8;
    localparam int CWS  = 2;
    localparam int MAXC = 8000;

    logic              clk = 1'b0;
    logic              reset;
    logic [CH-1:0]     sig_in;
    logic [2*CH-1:0]   mode;
    logic [CH-1:0]     clear;

    logic [CH-1:0]     level, pos_pulse, neg_pulse, event_flag;
    logic [CH*CW-1:0]  event_count;
    logic              irq;

    logic [CH-1:0]     s_level, s_pos, s_neg, s_flag;
    logic [CH*CWS-1:0] s_count;
    logic              s_irq;

    int checks = 0;
    int errors = 0;

    edge_event_unit #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_W(CW)) u_dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .mode(mode), .clear(clear),
        .level(level), .pos_pulse(pos_pulse), .neg_pulse(neg_pulse),
        .event_flag(event_flag), .event_count(event_count), .irq(irq)
    );

    edge_event_unit #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_W(CWS)) u_sat (
        .clk(clk), .reset(reset), .sig_in(sig_in), .mode(mode), .clear(clear),
        .level(s_level), .pos_pulse(s_pos), .neg_pulse(s_neg),
        .event_flag(s_flag), .event_count(s_count), .irq(s_irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Raw input history indexed by edge number; level toggles once the last
    // FC synchronised samples all disagree with it.
    logic [CH-1:0] raw_at [0:MAXC-1];
    int            cyc = 0;
    int            hist_base = 0;
    logic [CH-1:0] m_lvl, m_lvlp, m_flag;
    int            m_cnt  [CH];
    int            m_cnts [CH];

    function automatic bit get_raw(int idx, int ch);
        if (idx < hist_base) return 1'b0;
        return raw_at[idx][ch];
    endfunction

    task automatic model_reset();
        m_lvl = '0; m_lvlp = '0; m_flag = '0;
        for (int i = 0; i < CH; i++) begin m_cnt[i] = 0; m_cnts[i] = 0; end
        hist_base = cyc;
    endtask

    task automatic model_step();
        bit p, n, q, diff;
        if (cyc >= MAXC) begin
            $display("FAIL model_history cycles=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end
        if (reset) begin
            raw_at[cyc] = '0;
            cyc++;
            return;
        end
        for (int i = 0; i < CH; i++) begin
            p = m_lvl[i] & ~m_lvlp[i];
            n = ~m_lvl[i] & m_lvlp[i];
            q = (p & mode[2*i]) | (n & mode[2*i+1]);
            if (q) m_flag[i] = 1'b1;
            else if (clear[i]) m_flag[i] = 1'b0;
            if (clear[i]) begin
                m_cnt[i]  = q ? 1 : 0;
                m_cnts[i] = q ? 1 : 0;
            end else if (q) begin
                if (m_cnt[i]  < (1 << CW) - 1)  m_cnt[i]++;
                if (m_cnts[i] < (1 << CWS) - 1) m_cnts[i]++;
            end
            m_lvlp[i] = m_lvl[i];
            diff = 1'b1;
            // sync after edge e equals raw sampled at edge e-(SS-1)
            for (int j = 1; j <= FC; j++)
                if (get_raw(cyc - j - (SS - 1), i) == m_lvl[i]) diff = 1'b0;
            if (diff) m_lvl[i] = ~m_lvl[i];
        end
        raw_at[cyc] = sig_in;
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Drive ch high for 8 cycles then low for 8; report observed pulses.
    task automatic pulse_ch(input int ch, output int npos, output int nneg);
        npos = 0; nneg = 0;
        sig_in[ch] = 1'b1;
        for (int t = 0; t < 16; t++) begin
            if (t == 8) sig_in[ch] = 1'b0;
            tick();
            if (pos_pulse[ch]) npos++;
            if (neg_pulse[ch]) nneg++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int pos_t = -1, npos = 0;
        sig_in = '1;
        tick(); tick();
        checks++;
        if ({level, pos_pulse, neg_pulse, event_flag, event_count, irq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {level, pos_pulse, neg_pulse, event_flag, event_count, irq});
        end
        reset = 1'b0;
        // first edge after release samples the high input (edge 0)
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (pos_pulse != '0) begin
                npos++;
                if (pos_t < 0) pos_t = t;
                checks++;
                if (pos_pulse !== 4'hF || level !== 4'hF) begin
                    errors++;
                    $display("FAIL reset_release_pulse pos=%b level=%b want=1111", pos_pulse, level);
                end
            end
        end
        checks++;
        if (pos_t != 6 || npos != 1) begin
            errors++;
            $display("FAIL reset_release_timing tick=%0d count=%0d want tick=6 count=1", pos_t, npos);
        end
    endtask

    task automatic test_glitch();
        int npos = 0, pos_t = -1, neg_t = -1;
        sig_in = '0;
        repeat (12) tick();
        sig_in[0] = 1'b1;
        repeat (3) tick();
        sig_in[0] = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (pos_pulse[0] || level[0]) npos++;
        end
        checks++;
        if (npos != 0) begin
            errors++;
            $display("FAIL glitch_3cyc cycles_with_level_or_pulse=%0d want=0", npos);
        end
        sig_in[0] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 4) sig_in[0] = 1'b0;
            if (pos_pulse[0]) begin if (pos_t < 0) pos_t = t; else pos_t = 99; end
            if (neg_pulse[0]) begin if (neg_t < 0) neg_t = t; else neg_t = 99; end
        end
        checks++;
        if (pos_t != 6 || neg_t != 10) begin
            errors++;
            $display("FAIL glitch_4cyc pos_tick=%0d neg_tick=%0d want 6 and 10", pos_t, neg_t);
        end
    endtask

    task automatic test_mode();
        int np, nn;
        clear = '1; tick(); clear = '0;
        mode = 8'b00_00_01_00;
        pulse_ch(1, np, nn);
        checks++;
        if (event_count[CW*1 +: CW] !== 8'd1 || np != 1 || nn != 1) begin
            errors++;
            $display("FAIL mode_rise count=%0d pos=%0d neg=%0d want 1 1 1",
                     event_count[CW*1 +: CW], np, nn);
        end
        mode = 8'b00_00_11_00;
        pulse_ch(1, np, nn);
        checks++;
        if (event_count[CW*1 +: CW] !== 8'd3) begin
            errors++;
            $display("FAIL mode_both count=%0d want=3", event_count[CW*1 +: CW]);
        end
        mode = 8'b00_00_00_00;
        pulse_ch(1, np, nn);
        checks++;
        if (event_count[CW*1 +: CW] !== 8'd3 || event_flag[1] !== 1'b1) begin
            errors++;
            $display("FAIL mode_none count=%0d flag=%b want 3 1",
                     event_count[CW*1 +: CW], event_flag[1]);
        end
    endtask

    task automatic test_clear_collision();
        int np, nn;
        bit found = 1'b0;
        clear = '1; tick(); clear = '0;
        mode = 8'b00_11_00_00;
        pulse_ch(2, np, nn);
        pulse_ch(2, np, nn);
        sig_in[2] = 1'b1;
        repeat (8) tick();
        checks++;
        if (event_count[CW*2 +: CW] !== 8'd5) begin
            errors++;
            $display("FAIL collision_setup count=%0d want=5", event_count[CW*2 +: CW]);
        end
        sig_in[2] = 1'b0;
        for (int t = 0; t < 12 && !found; t++) begin
            tick();
            if (neg_pulse[2]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL collision_wait neg_pulse[2] not seen within 12 cycles");
        end
        clear[2] = 1'b1; tick(); clear = '0;
        checks++;
        if (event_flag[2] !== 1'b1 || event_count[CW*2 +: CW] !== 8'd1) begin
            errors++;
            $display("FAIL collision_set_wins flag=%b count=%0d want 1 1",
                     event_flag[2], event_count[CW*2 +: CW]);
        end
        clear = '1; tick(); clear = '0;
        checks++;
        if (event_flag !== '0 || event_count !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL clear_alone flag=%b count=%h irq=%b want 0 0 0",
                     event_flag, event_count, irq);
        end
    endtask

    task automatic test_saturation();
        int np, nn;
        clear = '1; tick(); clear = '0;
        mode = 8'b11_00_00_00;
        pulse_ch(3, np, nn);
        pulse_ch(3, np, nn);
        sig_in[3] = 1'b1;
        repeat (8) tick();
        checks++;
        if (s_count[CWS*3 +: CWS] !== 2'd3 || event_count[CW*3 +: CW] !== 8'd5) begin
            errors++;
            $display("FAIL saturation sat_count=%0d wide_count=%0d want 3 5",
                     s_count[CWS*3 +: CWS], event_count[CW*3 +: CW]);
        end
        sig_in[3] = 1'b0;
        repeat (8) tick();
        checks++;
        if (s_count[CWS*3 +: CWS] !== 2'd3 || s_flag[3] !== 1'b1) begin
            errors++;
            $display("FAIL saturation_hold sat_count=%0d flag=%b want 3 1",
                     s_count[CWS*3 +: CWS], s_flag[3]);
        end
    endtask

    task automatic test_reset_mid_filter();
        int bad = 0;
        sig_in = '0;
        repeat (12) tick();
        sig_in[0] = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({level, pos_pulse, neg_pulse, event_flag, event_count, irq,
             s_level, s_flag, s_count, s_irq} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs level=%b flag=%b count=%h irq=%b", level,
                     event_flag, event_count, irq);
        end
        sig_in = '0;
        tick(); tick();
        reset = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (pos_pulse != '0 || level != '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_no_pulse bad_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_random();
        logic [CH-1:0]     e_pos, e_neg;
        logic [CH*CW-1:0]  e_cnt;
        logic [CH*CWS-1:0] e_cnts;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(5) == 0) sig_in[i] = ~sig_in[i];
            if (t % 60 == 0) mode = 8'($urandom);
            for (int i = 0; i < CH; i++) clear[i] = ($urandom_range(24) == 0);
            if (t == 700) begin reset = 1'b1; model_reset(); end
            if (t == 703) reset = 1'b0;
            tick();
            e_pos = m_lvl & ~m_lvlp;
            e_neg = ~m_lvl & m_lvlp;
            for (int i = 0; i < CH; i++) begin
                e_cnt[CW*i +: CW]    = CW'(m_cnt[i]);
                e_cnts[CWS*i +: CWS] = CWS'(m_cnts[i]);
            end
            checks++;
            if (level !== m_lvl || pos_pulse !== e_pos || neg_pulse !== e_neg) begin
                errors++;
                $display("FAIL rand_level t=%0d got lvl=%b pos=%b neg=%b want %b %b %b",
                         t, level, pos_pulse, neg_pulse, m_lvl, e_pos, e_neg);
            end
            checks++;
            if (event_flag !== m_flag || event_count !== e_cnt || irq !== (|m_flag)) begin
                errors++;
                $display("FAIL rand_events t=%0d got flag=%b cnt=%h irq=%b want %b %h %b",
                         t, event_flag, event_count, irq, m_flag, e_cnt, |m_flag);
            end
            checks++;
            if (s_count !== e_cnts || s_flag !== m_flag || s_irq !== (|m_flag)) begin
                errors++;
                $display("FAIL rand_sat t=%0d got cnt=%h flag=%b want %h %b",
                         t, s_count, s_flag, e_cnts, m_flag);
            end
        end
        clear = '0;
    endtask

    initial begin
        reset  = 1'b1;
        sig_in = '1;
        mode   = '0;
        clear  = '0;
        model_reset();
        test_reset();
        test_glitch();
        test_mode();
        test_clear_collision();
        test_saturation();
        test_reset_mid_filter();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
